// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: owns the program counter, keeps at most one instruction-memory
// request outstanding, and hands decode a registered instruction with its PC+1. While a
// response is pending, NOP bubbles are fed downstream. Branch/jump redirects from execute
// retarget the PC and squash decode through the active-low flush.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   BS, PS, Z          branch select, conditional polarity and zero flag from execute
//   BrA, RAA           PC-relative and register branch targets from execute
//   imem_req/addr      one-cycle request strobe and address to instruction memory
//   imem_rdata/rvalid  response data and strobe from instruction memory
//   instruction        registered instruction presented to decode
//   pc_min_one         registered address-of-instruction + 1
//   flush              active-low squash to decode (combinational)
module instruction_fetch #(
  parameter int unsigned INSTRUCTION_BITS = 32,
  parameter int unsigned DATA_BITS        = 32,
  parameter logic [DATA_BITS-1:0]        RESET_PC  = '0,
  parameter logic [INSTRUCTION_BITS-1:0] NOP_INSTR = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  BS,
  input  logic                        PS,
  input  logic                        Z,
  input  logic [DATA_BITS-1:0]        BrA,
  input  logic [DATA_BITS-1:0]        RAA,
  output logic                        imem_req,
  output logic [DATA_BITS-1:0]        imem_addr,
  input  logic [INSTRUCTION_BITS-1:0] imem_rdata,
  input  logic                        imem_rvalid,
  output logic [INSTRUCTION_BITS-1:0] instruction,
  output logic [DATA_BITS-1:0]        pc_min_one,
  output logic                        flush
);

  // IDLE issues the very first fetch after reset, WAIT expects a wanted response,
  // DROP waits out a response that a redirect has made stale.
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDrop = 2'd2;

  localparam logic [DATA_BITS-1:0] PcOne = DATA_BITS'(1);

  logic [1:0]                  state_q, state_d;
  logic [DATA_BITS-1:0]        pc_q, pc_d;
  logic [INSTRUCTION_BITS-1:0] instr_q, instr_d;
  logic [DATA_BITS-1:0]        pmo_q, pmo_d;
  logic                        taken;
  logic [DATA_BITS-1:0]        target;
  logic [DATA_BITS-1:0]        pc_inc;

  always_comb begin
    taken  = ((BS == 2'b01) && (Z ^ PS)) || (BS == 2'b10) || (BS == 2'b11);
    target = (BS == 2'b10) ? RAA : BrA;
  end

  assign flush  = ~taken;
  assign pc_inc = pc_q + PcOne;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = NOP_INSTR;
    pmo_d     = pmo_q;
    imem_req  = 1'b0;
    imem_addr = pc_q;
    case (state_q)
      StIdle: begin
        imem_req = 1'b1;
        state_d  = StWait;
      end
      StWait: begin
        if (imem_rvalid) begin
          imem_req = 1'b1;
          if (taken) begin
            // Redirect wins over the arriving instruction; refetch at the target.
            pc_d      = target;
            imem_addr = target;
          end else begin
            instr_d   = imem_rdata;
            pmo_d     = pc_inc;
            pc_d      = pc_inc;
            imem_addr = pc_inc;
          end
        end else if (taken) begin
          // The outstanding response now belongs to the wrong path.
          pc_d    = target;
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (taken) begin
          pc_d = target;
        end
        if (imem_rvalid) begin
          imem_req  = 1'b1;
          imem_addr = taken ? target : pc_q;
          state_d   = StWait;
        end
      end
      default: state_d = StIdle;
    endcase
    if (rst) begin
      imem_req = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pmo_q   <= pmo_d;
    end
  end

  assign instruction = instr_q;
  assign pc_min_one  = pmo_q;

endmodule
